// File: rtl/mb32_issue_sched.sv
// Issue scheduler for the shared radix-8 Booth multiplier: round-robin grant between
// requesters A/B, operand recoding, in-flight tracking and a credit-protected result FIFO.

module mb32_booth_grp (
  input  logic [3:0] win,  // {x[3i+2], x[3i+1], x[3i], x[3i-1]}
  output logic       s,
  output logic       d,
  output logic       t,
  output logic       q,
  output logic       n
);
  logic [2:0] pos, mag;

  // digit = pos - 4*win[3]; a negative digit's magnitude is 4 - pos
  always_comb begin
    pos = {1'b0, win[2], 1'b0} + {2'b0, win[1]} + {2'b0, win[0]};
    mag = win[3] ? 3'd4 - pos : pos;
    s   = (mag == 3'd1);
    d   = (mag == 3'd2);
    t   = (mag == 3'd3);
    q   = (mag == 3'd4);
    n   = win[3] && (mag != 3'd0);
  end
endmodule

module mb32_issue_sched #(
  parameter int WIDTH      = 32,
  parameter int GROUP_CNT  = (WIDTH >> 2) + 3,
  parameter int MUL_LAT    = 2,
  parameter int TAG_W      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [WIDTH-1:0]     a_x,
  input  logic [WIDTH-1:0]     a_y,
  input  logic [TAG_W-1:0]     a_tag,
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [WIDTH-1:0]     b_x,
  input  logic [WIDTH-1:0]     b_y,
  input  logic [TAG_W-1:0]     b_tag,
  output logic [GROUP_CNT-1:0] s,
  output logic [GROUP_CNT-1:0] d,
  output logic [GROUP_CNT-1:0] t,
  output logic [GROUP_CNT-1:0] q,
  output logic [GROUP_CNT-1:0] n,
  output logic [WIDTH-1:0]     my,
  output logic [WIDTH+1:0]     tmy,
  input  logic [2*WIDTH-1:0]   product1,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [2*WIDTH-1:0]   res_data,
  output logic                 res_src,
  output logic [TAG_W-1:0]     res_tag
);
  localparam int CW   = $clog2(FIFO_DEPTH + 1);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int XE_W = 3 * GROUP_CNT + 1;

  typedef struct packed {
    logic             src;
    logic [TAG_W-1:0] tag;
  } meta_t;

  logic              rr;  // 0: A wins a tie, 1: B wins a tie
  logic [CW-1:0]     inflight_cnt, fifo_cnt;
  logic [CW:0]       occ;
  logic              credit, gnt_a, gnt_b, acc, push, pop;
  logic [WIDTH-1:0]  sel_x, sel_y;
  logic [XE_W-1:0]   xe;
  logic [WIDTH+1:0]  tmy_nx;
  logic [GROUP_CNT-1:0] s_nx, d_nx, t_nx, q_nx, n_nx;
  meta_t             acc_meta, head_meta;
  logic [MUL_LAT:0]  vld_pipe;
  meta_t [MUL_LAT:0] meta_pipe;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [2*WIDTH-1:0] dmem [FIFO_DEPTH];
  meta_t             mmem [FIFO_DEPTH];

  // A same-cycle pop is deliberately not credited back: counts are pre-edge only
  assign occ    = {1'b0, inflight_cnt} + {1'b0, fifo_cnt};
  assign credit = occ < (CW+1)'(FIFO_DEPTH);

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (credit) begin
      if (a_valid && (!b_valid || !rr)) gnt_a = 1'b1;
      else if (b_valid)                 gnt_b = 1'b1;
    end
  end

  assign a_ready  = gnt_a;
  assign b_ready  = gnt_b;
  assign acc      = gnt_a || gnt_b;
  assign sel_x    = gnt_b ? b_x : a_x;
  assign sel_y    = gnt_b ? b_y : a_y;
  assign acc_meta = gnt_b ? meta_t'{src: 1'b1, tag: b_tag} : meta_t'{src: 1'b0, tag: a_tag};

  // xe[j] holds x[j-1]: a zero below bit 0 and zero-extension above the top bit
  assign xe     = XE_W'({sel_x, 1'b0});
  assign tmy_nx = {2'b00, sel_y} + {1'b0, sel_y, 1'b0};

  for (genvar g = 0; g < GROUP_CNT; g++) begin : g_grp
    mb32_booth_grp u_grp (
      .win (xe[3*g+3 -: 4]),
      .s   (s_nx[g]),
      .d   (d_nx[g]),
      .t   (t_nx[g]),
      .q   (q_nx[g]),
      .n   (n_nx[g])
    );
  end

  // Idle cycles present zero operands so the multiplier yields zero
  always_ff @(posedge CLK) begin
    if (RST || !acc) begin
      s   <= '0;
      d   <= '0;
      t   <= '0;
      q   <= '0;
      n   <= '0;
      my  <= '0;
      tmy <= '0;
    end else begin
      s   <= s_nx;
      d   <= d_nx;
      t   <= t_nx;
      q   <= q_nx;
      n   <= n_nx;
      my  <= sel_y;
      tmy <= tmy_nx;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rr        <= 1'b0;
      vld_pipe  <= '0;
      meta_pipe <= '0;
    end else begin
      if (gnt_a)      rr <= 1'b1;
      else if (gnt_b) rr <= 1'b0;
      vld_pipe  <= {vld_pipe[MUL_LAT-1:0], acc};
      meta_pipe <= {meta_pipe[MUL_LAT-1:0], acc_meta};
    end
  end

  // Tail of the tracker lines up with product1 for that operation
  assign push      = vld_pipe[MUL_LAT];
  assign res_valid = (fifo_cnt != '0);
  assign pop       = res_valid && res_ready;
  assign res_data  = dmem[rd_ptr];
  assign head_meta = mmem[rd_ptr];
  assign res_src   = head_meta.src;
  assign res_tag   = head_meta.tag;

  always_ff @(posedge CLK) begin
    if (RST) begin
      inflight_cnt <= '0;
      fifo_cnt     <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
    end else begin
      case ({acc, push})
        2'b10:   inflight_cnt <= inflight_cnt + 1'b1;
        2'b01:   inflight_cnt <= inflight_cnt - 1'b1;
        default: inflight_cnt <= inflight_cnt;
      endcase
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      dmem[wr_ptr] <= product1;
      mmem[wr_ptr] <= meta_pipe[MUL_LAT];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST && push) assert (fifo_cnt != CW'(FIFO_DEPTH));
  end
endmodule

// File: tb/tb_mb32_issue_sched.sv
// Bench for mb32_issue_sched: behavioural Booth multiplier model, directed vectors with
// hand-computed products, and a decoupled scoreboard monitor on the result port.

module tb_mb32_issue_sched;
  localparam int WIDTH = 32;
  localparam int GC    = (WIDTH >> 2) + 3;
  localparam int LAT   = 2;

  logic CLK = 1'b0;
  logic RST;
  logic a_valid, a_ready, b_valid, b_ready;
  logic [WIDTH-1:0] a_x, a_y, b_x, b_y;
  logic [3:0] a_tag, b_tag;
  logic [GC-1:0] s, d, t, q, n;
  logic [WIDTH-1:0] my;
  logic [WIDTH+1:0] tmy;
  logic [2*WIDTH-1:0] product1 = '0, m1 = '0;
  logic res_valid, res_ready, res_src;
  logic [2*WIDTH-1:0] res_data;
  logic [3:0] res_tag;

  mb32_issue_sched #(.WIDTH(WIDTH), .MUL_LAT(LAT), .TAG_W(4), .FIFO_DEPTH(4)) dut (
    .CLK(CLK), .RST(RST),
    .a_valid(a_valid), .a_ready(a_ready), .a_x(a_x), .a_y(a_y), .a_tag(a_tag),
    .b_valid(b_valid), .b_ready(b_ready), .b_x(b_x), .b_y(b_y), .b_tag(b_tag),
    .s(s), .d(d), .t(t), .q(q), .n(n), .my(my), .tmy(tmy), .product1(product1),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_src(res_src), .res_tag(res_tag)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] x, y;
    logic [3:0]  tag;
    logic [63:0] prod;
    bit          lat;
  } vec_t;

  typedef struct {
    logic [63:0] prod;
    logic        src;
    logic [3:0]  tag;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t sb[$];
  bit   acc_log[$];
  int   acc_cyc[$];
  int   cyc = 0;
  int   n_chk = 0, n_pass = 0;
  logic [63:0] a_prod, b_prod;
  bit   a_lat, b_lat;

  function automatic vec_t mk(input logic [31:0] x, input logic [31:0] y,
                              input logic [3:0] tag, input logic [63:0] prod, input bit lat);
    vec_t v;
    v.x = x; v.y = y; v.tag = tag; v.prod = prod; v.lat = lat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  // External multiplier: sums Booth digits times my (tmy for magnitude 3), two register stages
  function automatic logic [63:0] mul_model(input logic [GC-1:0] fs, input logic [GC-1:0] fd,
      input logic [GC-1:0] ft, input logic [GC-1:0] fq, input logic [GC-1:0] fn,
      input logic [31:0] fy, input logic [33:0] fty);
    logic [127:0] sum, term;
    sum = '0;
    for (int i = 0; i < GC; i++) begin
      term = '0;
      if (fs[i])      term = 128'(fy);
      else if (fd[i]) term = 128'(fy) << 1;
      else if (ft[i]) term = 128'(fty);
      else if (fq[i]) term = 128'(fy) << 2;
      term = term << (3 * i);
      sum  = fn[i] ? sum - term : sum + term;
    end
    return sum[63:0];
  endfunction

  always @(posedge CLK) begin
    m1       <= mul_model(s, d, t, q, n, my, tmy);
    product1 <= m1;
    cyc      <= cyc + 1;
  end

  // Scoreboard: record accepts, compare each popped result against the head
  always @(negedge CLK) begin
    if (RST) sb.delete();
    else begin
      if (res_valid && res_ready) begin
        if (sb.size() == 0) chk("unexpected_result", res_data, 64'hDEAD);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("res_data", res_data, e.prod);
          chk("res_src_tag", 64'({res_src, res_tag}), 64'({e.src, e.tag}));
          if (e.lat) chk("latency", 64'(cyc - e.cyc), 64'(LAT + 2));
        end
      end
      if (a_valid && a_ready) begin
        sb.push_back('{prod: a_prod, src: 1'b0, tag: a_tag, cyc: cyc, lat: a_lat});
        acc_log.push_back(1'b0);
        acc_cyc.push_back(cyc);
      end
      if (b_valid && b_ready) begin
        sb.push_back('{prod: b_prod, src: 1'b1, tag: b_tag, cyc: cyc, lat: b_lat});
        acc_log.push_back(1'b1);
        acc_cyc.push_back(cyc);
      end
    end
  end

  // Requester hold rule: a stalled request must stay valid and stable
  logic pa_v = 0, pa_r = 0, pb_v = 0, pb_r = 0;
  logic [67:0] pa_d = '0, pb_d = '0;
  always @(negedge CLK) begin
    if (!RST && pa_v && !pa_r) assert (a_valid && {a_x, a_y, a_tag} == pa_d)
      else $error("requester A broke the hold rule");
    if (!RST && pb_v && !pb_r) assert (b_valid && {b_x, b_y, b_tag} == pb_d)
      else $error("requester B broke the hold rule");
    pa_v <= a_valid; pa_r <= a_ready; pa_d <= {a_x, a_y, a_tag};
    pb_v <= b_valid; pb_r <= b_ready; pb_d <= {b_x, b_y, b_tag};
  end

  task automatic drive_a(input vec_t v);
    int k;
    a_x = v.x; a_y = v.y; a_tag = v.tag; a_prod = v.prod; a_lat = v.lat; a_valid = 1'b1;
    k = 0;
    do begin @(negedge CLK); k++; end while (!a_ready && k < 500);
    if (!a_ready) chk("a_accept_timeout", 64'(k), 64'd0);
    @(posedge CLK); #1;
    a_valid = 1'b0;
  endtask

  task automatic drive_b(input vec_t v);
    int k;
    b_x = v.x; b_y = v.y; b_tag = v.tag; b_prod = v.prod; b_lat = v.lat; b_valid = 1'b1;
    k = 0;
    do begin @(negedge CLK); k++; end while (!b_ready && k < 500);
    if (!b_ready) chk("b_accept_timeout", 64'(k), 64'd0);
    @(posedge CLK); #1;
    b_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 300) begin @(negedge CLK); k++; end
    chk(name, 64'(sb.size()), 64'd0);
  endtask

  task automatic do_reset();
    @(posedge CLK); #1 RST = 1'b1;
    @(posedge CLK); #1 RST = 1'b0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int start, k;
    bit rand_done;
    RST = 1'b1; a_valid = 0; b_valid = 0; res_ready = 1'b1;
    a_x = '0; a_y = '0; a_tag = '0; b_x = '0; b_y = '0; b_tag = '0;
    a_prod = '0; b_prod = '0; a_lat = 0; b_lat = 0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("rst_groups", 64'({s, d, t, q, n}), 64'd0);
    chk("rst_my_tmy", 64'(my) | 64'(tmy), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);

    // 5*3: group0 digit -3, group1 digit +1
    drive_a(mk(32'd5, 32'd3, 4'd7, 64'd15, 1));
    @(negedge CLK);
    chk("t1_s", 64'(s), 64'h002);
    chk("t1_t", 64'(t), 64'h001);
    chk("t1_n", 64'(n), 64'h001);
    chk("t1_dq", 64'({d, q}), 64'd0);
    chk("t1_my_tmy", {30'd0, tmy}, 64'd9);
    @(negedge CLK);
    chk("t1_idle", 64'({s, d, t, q, n}) | 64'(my), 64'd0);
    drain("t1_drain");

    // all ones: group0 -1, group10 +4, rest 0
    drive_a(mk(32'hFFFFFFFF, 32'hFFFFFFFF, 4'd2, 64'hFFFFFFFE00000001, 1));
    @(negedge CLK);
    chk("t2_tmy", 64'(tmy), 64'h2FFFFFFFD);
    chk("t2_my", 64'(my), 64'hFFFFFFFF);
    chk("t2_sqn", 64'({s, q, n}), {31'd0, 11'h001, 11'h400, 11'h001});
    chk("t2_dt", 64'({d, t}), 64'd0);
    drain("t2_drain");

    // both continuously valid after reset: A,B,A,B,A,B
    do_reset();
    start = acc_log.size();
    fork
      begin
        drive_a(mk(32'd0, 32'h1234, 4'd1, 64'd0, 0));
        drive_a(mk(32'd7, 32'd6, 4'd3, 64'd42, 0));
        drive_a(mk(32'h80000000, 32'd2, 4'd5, 64'h100000000, 0));
      end
      begin
        drive_b(mk(32'h80000000, 32'd2, 4'd2, 64'h100000000, 0));
        drive_b(mk(32'd0, 32'd99, 4'd4, 64'd0, 0));
        drive_b(mk(32'h10, 32'h10, 4'd6, 64'h100, 0));
      end
    join
    chk("t3_order", 64'({acc_log[start], acc_log[start+1], acc_log[start+2],
                        acc_log[start+3], acc_log[start+4], acc_log[start+5]}), 64'b010101);
    for (int i = 0; i < 3; i++)
      chk("t3_b2b", 64'(acc_cyc[start+i+1] - acc_cyc[start+i]), 64'd1);
    drain("t3_drain");

    // credit stall: res_ready low lets exactly four through
    @(posedge CLK); #1 res_ready = 1'b0;
    start = acc_log.size();
    fork
      begin
        drive_a(mk(32'd3, 32'd5, 4'd8, 64'd15, 0));
        drive_a(mk(32'd100, 32'd100, 4'd9, 64'd10000, 0));
        drive_a(mk(32'h10000, 32'h10000, 4'd10, 64'h100000000, 0));
      end
      begin
        drive_b(mk(32'd2, 32'd2, 4'd11, 64'd4, 0));
        drive_b(mk(32'hFFFF, 32'h10001, 4'd12, 64'hFFFFFFFF, 0));
        drive_b(mk(32'd9, 32'd9, 4'd13, 64'd81, 0));
      end
      begin
        repeat (12) @(negedge CLK);
        chk("t4_stall_accepts", 64'(acc_log.size() - start), 64'd4);
        chk("t4_ready_low", 64'({a_ready, b_ready}), 64'd0);
        chk("t4_res_valid", 64'(res_valid), 64'd1);
        @(posedge CLK); #1 res_ready = 1'b1;
      end
    join
    drain("t4_drain");

    // reset with operations in flight discards them
    drive_a(mk(32'd11, 32'd13, 4'd1, 64'd143, 0));
    drive_a(mk(32'd6, 32'd7, 4'd2, 64'd42, 0));
    drive_a(mk(32'd9, 32'd10, 4'd3, 64'd90, 0));
    RST = 1'b1;
    @(posedge CLK); #1 RST = 1'b0;
    @(negedge CLK);
    chk("t5_groups_zero", 64'({s, d, t, q, n}), 64'd0);
    chk("t5_my_tmy_zero", 64'(my) | 64'(tmy), 64'd0);
    chk("t5_res_valid", 64'(res_valid), 64'd0);
    k = 0;
    repeat (8) begin @(negedge CLK); if (res_valid) k++; end
    chk("t5_no_stale_result", 64'(k), 64'd0);
    start = acc_log.size();
    fork
      drive_a(mk(32'd20, 32'd30, 4'd4, 64'd600, 1));
      drive_b(mk(32'd40, 32'd50, 4'd5, 64'd2000, 0));
    join
    chk("t5_ptr_favours_a", 64'(acc_log[start]), 64'd0);
    drain("t5_drain");

    // random traffic with random consumer back-pressure
    rand_done = 0;
    fork
      begin
        fork
          for (int i = 0; i < 250; i++) begin
            logic [31:0] rx, ry;
            rx = $urandom; ry = $urandom;
            repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
            drive_a(mk(rx, ry, 4'(i), 64'(rx) * 64'(ry), 0));
          end
          for (int j = 0; j < 250; j++) begin
            logic [31:0] sx, sy;
            sx = $urandom; sy = $urandom;
            repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
            drive_b(mk(sx, sy, 4'(j), 64'(sx) * 64'(sy), 0));
          end
        join
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge CLK); #1;
          res_ready = ($urandom_range(0, 3) != 0);
        end
        res_ready = 1'b1;
      end
    join
    drain("t6_drain");
    @(negedge CLK);
    chk("final_res_valid", 64'(res_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
